// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO console FIFO, status and cycle counter.
// Optional CYCLE register is built only when DMEM_CYCLE_COUNTER_EN is defined.
module dmem_responder #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWrite,
  input  logic [15:0] addr,
  input  logic [15:0] writeData,
  output logic [15:0] readData,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow
);

  localparam int             PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [14:0]    BASE_W  = MMIO_BASE[15:1];

  logic [15:0] mem_q [2**ADDR_WIDTH];
  logic [15:0] fifo_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [ADDR_WIDTH-1:0] idx;
  logic [14:0]           off_w;
  logic sel_mmio, sel_console, sel_status, sel_cycle;
  logic full, empty, push, pop, wr_en, ovf_clr;
  logic [15:0] cyc_rd;

  // Decode works on word offsets so byte bit 0 never matters.
  assign idx         = addr[ADDR_WIDTH:1];
  assign sel_mmio    = (addr >= MMIO_BASE);
  assign off_w       = addr[15:1] - BASE_W;
  assign sel_console = sel_mmio && (off_w == 15'd0);
  assign sel_status  = sel_mmio && (off_w == 15'd1);
  assign sel_cycle   = sel_mmio && (off_w == 15'd2);

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign tx_valid = !empty;
  assign tx_data  = empty ? 16'h0000 : fifo_q[rd_ptr_q];
  assign overflow = ovf_q;

  always_comb begin
    push     = memWrite && sel_console;
    pop      = tx_valid && tx_ready;
    wr_en    = push && (!full || pop);
    ovf_clr  = memWrite && sel_status && writeData[2];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
    if (ovf_clr) ovf_d = 1'b0;
    // A dropped push outranks a same-cycle clear.
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) fifo_q[wr_ptr_q] <= writeData;
  end

  always_ff @(posedge clk) begin
    if (memWrite && !sel_mmio) mem_q[idx] <= writeData;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q + 16'd1;
    if (memWrite && sel_cycle) cyc_d = writeData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= 16'h0000;
    else     cyc_q <= cyc_d;
  end

  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = 16'h0000;
`endif

  always_comb begin
    readData = 16'h0000;
    if (!sel_mmio)       readData = mem_q[idx];
    else if (sel_status) readData = {13'b0, ovf_q, full, empty};
    else if (sel_cycle)  readData = cyc_rd;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: RAM, console FIFO scoreboard, status, counter, async reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        memWrite;
  logic [15:0] addr;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow;

  int vec  = 0;
  int errs = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp;

`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  dmem_responder #(.ADDR_WIDTH(8), .FIFO_DEPTH(4), .MMIO_BASE(16'hFF00)) dut (
    .clk(clk), .rst(rst), .memWrite(memWrite), .addr(addr), .writeData(writeData),
    .readData(readData), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; memWrite = 1'b0; addr = 16'hFF02; writeData = 16'h0; tx_ready = 1'b0;
    @(negedge clk); #1;
    vec++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL rst_tx_valid got %h want 0", tx_valid); end
    vec++; if (tx_data !== 16'h0) begin errs++; $display("FAIL rst_tx_data got %h want 0000", tx_data); end
    vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL rst_overflow got %h want 0", overflow); end
    vec++; if (readData !== 16'h0001) begin errs++; $display("FAIL rst_status got %h want 0001", readData); end
    addr = 16'hFF04; #1;
    vec++; if (readData !== 16'h0000) begin errs++; $display("FAIL rst_cycle got %h want 0000", readData); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ram();
    memWrite = 1'b1; addr = 16'h0010; writeData = 16'hBEEF;
    @(negedge clk);
    memWrite = 1'b1; addr = 16'h01FE; writeData = 16'h5A5A;
    @(negedge clk);
    memWrite = 1'b0; addr = 16'h0010; #1;
    vec++; if (readData !== 16'hBEEF) begin errs++; $display("FAIL ram_read got %h want BEEF", readData); end
    addr = 16'h0210; #1;
    vec++; if (readData !== 16'hBEEF) begin errs++; $display("FAIL ram_alias got %h want BEEF", readData); end
    addr = 16'h01FF; #1;
    vec++; if (readData !== 16'h5A5A) begin errs++; $display("FAIL ram_top got %h want 5A5A", readData); end
    memWrite = 1'b1; addr = 16'h0010; writeData = 16'h1234; #1;
    vec++; if (readData !== 16'hBEEF) begin errs++; $display("FAIL ram_old_on_write got %h want BEEF", readData); end
    @(negedge clk);
    memWrite = 1'b0; #1;
    vec++; if (readData !== 16'h1234) begin errs++; $display("FAIL ram_new got %h want 1234", readData); end
    memWrite = 1'b1; addr = 16'hFF06; writeData = 16'hFFFF;
    @(negedge clk);
    memWrite = 1'b0; #1;
    vec++; if (readData !== 16'h0000) begin errs++; $display("FAIL mmio_other got %h want 0000", readData); end
  endtask

  task automatic test_console_drain();
    logic [15:0] vals [3] = '{16'h0041, 16'h0042, 16'h0043};
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      memWrite = 1'b1; addr = 16'hFF00; writeData = vals[i];
      if (i == 0) begin
        #1;
        vec++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL no_bypass got %h want 0", tx_valid); end
      end
      exp_q.push_back(vals[i]);
      @(negedge clk);
    end
    memWrite = 1'b0; addr = 16'hFF00; #1;
    vec++; if (readData !== 16'h0000) begin errs++; $display("FAIL console_read got %h want 0000", readData); end
    addr = 16'hFF02; #1;
    vec++; if (tx_valid !== 1'b1) begin errs++; $display("FAIL drain_valid got %h want 1", tx_valid); end
    vec++; if (tx_data !== 16'h0041) begin errs++; $display("FAIL drain_head got %h want 0041", tx_data); end
    vec++; if (readData !== 16'h0000) begin errs++; $display("FAIL drain_status got %h want 0000", readData); end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp = 16'hDEAD;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      vec++; if (tx_valid !== 1'b1 || tx_data !== exp) begin
        errs++; $display("FAIL drain_pop%0d got v=%h d=%h want v=1 d=%h", i, tx_valid, tx_data, exp);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0; #1;
    vec++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL drain_empty got %h want 0", tx_valid); end
    vec++; if (readData !== 16'h0001) begin errs++; $display("FAIL drain_status_end got %h want 0001", readData); end
  endtask

  task automatic test_overflow();
    int cnt = 0;
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      memWrite = 1'b1; addr = 16'hFF00; writeData = 16'(i);
      if (cnt < 4) begin exp_q.push_back(16'(i)); cnt++; end
      @(negedge clk);
    end
    memWrite = 1'b0; addr = 16'hFF02; #1;
    vec++; if (readData !== 16'h0006) begin errs++; $display("FAIL ovf_status got %h want 0006", readData); end
    vec++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag got %h want 1", overflow); end
    memWrite = 1'b1; writeData = 16'h0004;
    @(negedge clk);
    memWrite = 1'b0; #1;
    vec++; if (readData !== 16'h0002) begin errs++; $display("FAIL ovf_clear got %h want 0002", readData); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = 16'hDEAD;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      vec++; if (tx_valid !== 1'b1 || tx_data !== exp) begin
        errs++; $display("FAIL ovf_pop%0d got v=%h d=%h want v=1 d=%h", i, tx_valid, tx_data, exp);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0; #1;
    vec++; if (readData !== 16'h0001) begin errs++; $display("FAIL ovf_drained got %h want 0001", readData); end
  endtask

  task automatic test_full_push_pop();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      memWrite = 1'b1; addr = 16'hFF00; writeData = 16'h0010 + 16'(i);
      exp_q.push_back(16'h0010 + 16'(i));
      @(negedge clk);
    end
    memWrite = 1'b0; addr = 16'hFF02; #1;
    vec++; if (readData !== 16'h0002) begin errs++; $display("FAIL full_status got %h want 0002", readData); end
    memWrite = 1'b1; addr = 16'hFF00; writeData = 16'h00AA; tx_ready = 1'b1; #1;
    exp = 16'hDEAD;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    vec++; if (tx_data !== exp) begin errs++; $display("FAIL full_pp_pop got %h want %h", tx_data, exp); end
    exp_q.push_back(16'h00AA);
    @(negedge clk);
    memWrite = 1'b0; tx_ready = 1'b0; addr = 16'hFF02; #1;
    vec++; if (readData !== 16'h0002) begin errs++; $display("FAIL full_pp_status got %h want 0002", readData); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = 16'hDEAD;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      vec++; if (tx_valid !== 1'b1 || tx_data !== exp) begin
        errs++; $display("FAIL full_pp_drain%0d got v=%h d=%h want v=1 d=%h", i, tx_valid, tx_data, exp);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0; #1;
    vec++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL full_pp_empty got %h want 0", tx_valid); end
  endtask

  task automatic test_counter();
    logic [15:0] seq [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    rst = 1'b1; #1; rst = 1'b0;
    @(negedge clk); @(negedge clk);
    addr = 16'hFF04; #1;
    exp = CNT_EN ? 16'h0002 : 16'h0000;
    vec++; if (readData !== exp) begin errs++; $display("FAIL cyc_after_rst got %h want %h", readData, exp); end
    memWrite = 1'b1; writeData = 16'hFFFE;
    @(negedge clk);
    memWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp = CNT_EN ? seq[i] : 16'h0000;
      vec++; if (readData !== exp) begin errs++; $display("FAIL cyc_load%0d got %h want %h", i, readData, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      memWrite = 1'b1; addr = 16'hFF00; writeData = 16'h0070 + 16'(i);
      if (i < 4) exp_q.push_back(16'h0070 + 16'(i));
      @(negedge clk);
    end
    memWrite = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      exp = 16'hDEAD;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      vec++; if (tx_data !== exp) begin errs++; $display("FAIL ar_pop%0d got %h want %h", i, tx_data, exp); end
      @(negedge clk);
    end
    tx_ready = 1'b0; addr = 16'hFF02; #1;
    vec++; if (readData !== 16'h0004) begin errs++; $display("FAIL ar_pre_status got %h want 0004", readData); end
    rst = 1'b1; #1;
    vec++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL ar_tx_valid got %h want 0", tx_valid); end
    vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL ar_overflow got %h want 0", overflow); end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk); #1;
    vec++; if (readData !== 16'h0001) begin errs++; $display("FAIL ar_post_status got %h want 0001", readData); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_console_drain();
    test_overflow();
    test_full_push_pop();
    test_counter();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
